// File: rtl/kbd_text_writer.sv
// Keyboard-to-text-memory bridge: buffers decoded key characters in a FIFO and
// drains them into the memory-mapped text buffer while tracking a wrapping cursor.
module kbd_text_writer #(
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       ADDR_W    = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'hf00),
    parameter int unsigned       LINE_LEN  = 70,
    parameter int unsigned       LINES     = 30,
    parameter int unsigned       PULSE_LEN = 32,
    localparam int unsigned      CUR_W     = $clog2(LINE_LEN * LINES),
    localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              key_ready,
    input  logic [7:0]        key_ascii,
    input  logic [2:0]        key_mode,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    input  logic              mem_ack,
    output logic              k_change,
    output logic [CUR_W-1:0]  pos,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned COL_W  = $clog2(LINE_LEN);
    localparam int unsigned LINE_W = $clog2(LINES);
    localparam int unsigned PCNT_W = $clog2(PULSE_LEN + 1);
    localparam int unsigned CELLS  = LINE_LEN * LINES;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_e;

    state_e              state_q, state_d;
    logic                key_ready_q, key_ready_d;
    logic [7:0]          fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CUR_W-1:0]    pos_q, pos_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                overflow_q, overflow_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_data_q, mem_data_d;
    logic                k_change_q, k_change_d;
    logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic                is_print_q, is_print_d;

    logic       rise, mode_ok, push_req, push_ok, pop, fifo_full, fifo_we;
    logic [7:0] head;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CUR_W-1:0] p);
        return BASE_ADDR + ADDR_W'({p, 2'b00});
    endfunction

    assign rise      = key_ready & ~key_ready_q;
    assign mode_ok   = (key_mode == 3'd1) || (key_mode == 3'd3) || (key_mode == 3'd4);
    assign push_req  = rise && (key_ascii != 8'h00) && mode_ok;
    assign head      = fifo_mem_q[rd_ptr_q];
    assign fifo_full = (count_q == CNT_W'(DEPTH));
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok   = push_req && (!fifo_full || pop);

    always_comb begin
        state_d     = state_q;
        key_ready_d = key_ready;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pos_d       = pos_q;
        col_d       = col_q;
        line_d      = line_q;
        overflow_d  = overflow_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        k_change_d  = k_change_q;
        pulse_cnt_d = pulse_cnt_q;
        is_print_d  = is_print_q;
        fifo_we     = 1'b0;

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pos_d       = '0;
            col_d       = '0;
            line_d      = '0;
            overflow_d  = 1'b0;
            state_d     = S_IDLE;
            mem_we_d    = 1'b0;
            k_change_d  = 1'b0;
            pulse_cnt_d = '0;
        end else begin
            if (push_ok) begin
                fifo_we  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (push_req && !push_ok) overflow_d = 1'b1;
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        if (head >= 8'h20 && head <= 8'h7e) begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = cell_addr(pos_q);
                            mem_data_d = {24'h0, head};
                            is_print_d = 1'b1;
                            state_d    = S_ISSUE;
                        end else if (head == 8'h0d || head == 8'h0a) begin
                            col_d = '0;
                            if (line_q == LINE_W'(LINES - 1)) begin
                                line_d = '0;
                                pos_d  = '0;
                            end else begin
                                line_d = line_q + LINE_W'(1);
                                pos_d  = pos_q - CUR_W'(col_q) + CUR_W'(LINE_LEN);
                            end
                        end else if (head == 8'h08 && pos_q != '0) begin
                            // Cursor moves back at the pop so the blank lands on the new cell
                            pos_d = pos_q - CUR_W'(1);
                            if (col_q == '0) begin
                                col_d  = COL_W'(LINE_LEN - 1);
                                line_d = line_q - LINE_W'(1);
                            end else begin
                                col_d = col_q - COL_W'(1);
                            end
                            mem_we_d   = 1'b1;
                            mem_addr_d = cell_addr(pos_q - CUR_W'(1));
                            mem_data_d = 32'h0000_0020;
                            is_print_d = 1'b0;
                            state_d    = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_ack) begin
                        mem_we_d    = 1'b0;
                        k_change_d  = 1'b1;
                        pulse_cnt_d = '0;
                        state_d     = S_HOLD;
                        if (is_print_q) begin
                            pos_d = (pos_q == CUR_W'(CELLS - 1)) ? '0 : pos_q + CUR_W'(1);
                            if (col_q == COL_W'(LINE_LEN - 1)) begin
                                col_d  = '0;
                                line_d = (line_q == LINE_W'(LINES - 1)) ? '0 : line_q + LINE_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (pulse_cnt_q == PCNT_W'(PULSE_LEN - 1)) begin
                        k_change_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_ready_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pos_q       <= '0;
            col_q       <= '0;
            line_q      <= '0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_data_q  <= '0;
            k_change_q  <= 1'b0;
            pulse_cnt_q <= '0;
            is_print_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_ready_q <= key_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pos_q       <= pos_d;
            col_q       <= col_d;
            line_q      <= line_d;
            overflow_q  <= overflow_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            k_change_q  <= k_change_d;
            pulse_cnt_q <= pulse_cnt_d;
            is_print_q  <= is_print_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid
    always_ff @(posedge CLOCK_50) begin
        if (rst_n && fifo_we) fifo_mem_q[wr_ptr_q] <= key_ascii;
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign k_change   = k_change_q;
    assign pos        = pos_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_text_writer.sv
// Bench for kbd_text_writer: directed scenarios plus random key streams checked
// against a cursor/write model built from plain integer arithmetic.
module tb_kbd_text_writer;

    localparam int BASE     = 'hf00;
    localparam int LINE_LEN = 70;
    localparam int LINES    = 30;
    localparam int CELLS    = LINE_LEN * LINES;

    logic        clk = 1'b0;
    logic        rst_n, clear, key_ready, mem_ack;
    logic [7:0]  key_ascii;
    logic [2:0]  key_mode;
    logic        mem_we, k_change, overflow;
    logic [18:0] mem_addr;
    logic [31:0] mem_data;
    logic [11:0] pos;
    logic [4:0]  fifo_count;

    int n_chk = 0;
    int n_bad = 0;
    int ack_mode = 1;
    int writes = 0;
    int we_cycles = 0;
    int last_addr = 0;
    int last_data = 0;
    int m_pos = 0;
    int exp_addr[$];
    int exp_data[$];

    kbd_text_writer dut (
        .CLOCK_50  (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .key_ready (key_ready),
        .key_ascii (key_ascii),
        .key_mode  (key_mode),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .k_change  (k_change),
        .pos       (pos),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what a filtered key does to the cursor and which write it causes
    function automatic void model_key(input int mode, input int ch);
        if (ch == 0 || !(mode == 1 || mode == 3 || mode == 4)) return;
        if (ch >= 'h20 && ch <= 'h7e) begin
            exp_addr.push_back((BASE + 4 * m_pos) & 'h7ffff);
            exp_data.push_back(ch);
            m_pos = (m_pos + 1) % CELLS;
        end else if (ch == 'h0d || ch == 'h0a) begin
            m_pos = ((m_pos / LINE_LEN + 1) * LINE_LEN) % CELLS;
        end else if (ch == 'h08 && m_pos > 0) begin
            m_pos = m_pos - 1;
            exp_addr.push_back((BASE + 4 * m_pos) & 'h7ffff);
            exp_data.push_back('h20);
        end
    endfunction

    always @(posedge clk) begin
        #2;
        case (ack_mode)
            0:       mem_ack = 1'b0;
            1:       mem_ack = 1'b1;
            default: mem_ack = ($urandom_range(0, 3) == 0);
        endcase
    end

    // Every accepted write must be the next one the model predicts
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            we_cycles++;
            if (mem_ack) begin
                writes++;
                last_addr = int'(mem_addr);
                last_data = int'(mem_data);
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", 32'(mem_addr), 32'hffff_ffff);
                end else begin
                    check("wr_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                    check("wr_data", mem_data, 32'(exp_data.pop_front()));
                end
            end
        end
    end

    task automatic send_raw(input int mode, input int ch, input int hold);
        key_mode  = 3'(mode);
        key_ascii = 8'(ch);
        key_ready = 1'b1;
        repeat (hold) @(negedge clk);
        key_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_key(input int mode, input int ch, input int hold);
        model_key(mode, ch);
        send_raw(mode, ch, hold);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!(fifo_count == 0 && !mem_we && !k_change) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        m_pos = 0;
    endtask

    function automatic int rand_char();
        int r = $urandom_range(0, 9);
        case (r)
            0:       return 'h0d;
            1:       return 'h0a;
            2:       return 'h08;
            3:       return 'h00;
            4:       return $urandom_range(0, 255);
            default: return $urandom_range(32, 126);
        endcase
    endfunction

    initial begin
        int w0, c0, kc;
        rst_n = 1'b0; clear = 1'b0; key_ready = 1'b0;
        key_ascii = 8'h0; key_mode = 3'd0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 32'h0f00);
        check("rst_data", mem_data, 0);
        check("rst_kchange", 32'(k_change), 0);
        check("rst_pos", 32'(pos), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single character with ack tied high
        ack_mode = 1;
        model_key(1, 'h41);
        key_mode = 3'd1; key_ascii = 8'h41; key_ready = 1'b1;
        @(negedge clk);
        check("single_push_count", 32'(fifo_count), 1);
        check("single_no_we_yet", 32'(mem_we), 0);
        @(negedge clk);
        check("single_we", 32'(mem_we), 1);
        check("single_addr", 32'(mem_addr), 32'h0f00);
        check("single_data", mem_data, 32'h41);
        check("single_pos_pre", 32'(pos), 0);
        @(negedge clk);
        key_ready = 1'b0;
        check("single_we_done", 32'(mem_we), 0);
        check("single_pos", 32'(pos), 1);
        kc = 0;
        for (int i = 0; i < 100; i++) begin
            if (k_change) kc++;
            else if (kc > 0) break;
            @(negedge clk);
        end
        check("single_kchange_len", 32'(kc), 32);
        wait_drain(200);

        // Mode and zero filter
        w0 = writes; c0 = we_cycles;
        send_key(2, 'h41, 1);
        check("filt_mode2", 32'(fifo_count), 0);
        send_key(1, 'h00, 1);
        check("filt_zero", 32'(fifo_count), 0);
        send_key(5, 'h42, 1);
        check("filt_mode5", 32'(fifo_count), 0);
        repeat (4) @(negedge clk);
        check("filt_no_we", 32'(we_cycles - c0), 0);
        check("filt_pos", 32'(pos), 1);

        // Rise on the clear edge is discarded
        key_mode = 3'd1; key_ascii = 8'h43; key_ready = 1'b1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_addr.delete(); exp_data.delete(); m_pos = 0;
        check("clr_rise_count", 32'(fifo_count), 0);
        key_ready = 1'b0;
        @(negedge clk);
        check("clr_rise_we", 32'(mem_we), 0);
        check("clr_rise_pos", 32'(pos), 0);

        // Buffering and overflow with acks withheld
        ack_mode = 0;
        w0 = writes;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) send_key(1, 'h61 + i, 1);
            else        send_raw(1, 'h61 + i, 1);
        end
        check("ovf_issue_we", 32'(mem_we), 1);
        check("ovf_count", 32'(fifo_count), 16);
        check("ovf_flag", 32'(overflow), 1);
        ack_mode = 2;
        wait_drain(4000);
        check("ovf_writes", 32'(writes - w0), 17);
        check("ovf_pos", 32'(pos), 17);
        check("ovf_sticky", 32'(overflow), 1);
        do_clear();
        check("ovf_cleared", 32'(overflow), 0);
        check("ovf_clr_pos", 32'(pos), 0);

        // Wrap at the last cell
        for (int i = 0; i < 29; i++) begin
            send_key(1, (i % 2 == 0) ? 'h0d : 'h0a, 1);
            wait_drain(100);
        end
        check("wrap_lines", 32'(pos), 2030);
        for (int i = 0; i < 69; i++) begin
            send_key(1, $urandom_range(32, 126), 1);
            wait_drain(300);
        end
        check("wrap_pos_last", 32'(pos), 2099);
        send_key(1, 'h5a, 2);
        wait_drain(300);
        check("wrap_addr", 32'(last_addr), 32'h2fcc);
        check("wrap_data", 32'(last_data), 32'h5a);
        check("wrap_pos_zero", 32'(pos), 0);

        // CR on the last line wraps with no write
        for (int i = 0; i < 29; i++) begin
            send_key(3, 'h0d, 1);
            wait_drain(100);
        end
        for (int i = 0; i < 50; i++) begin
            send_key(4, $urandom_range(32, 126), 1);
            wait_drain(300);
        end
        check("cr_pos_2080", 32'(pos), 2080);
        w0 = writes; c0 = we_cycles;
        send_key(1, 'h0d, 1);
        wait_drain(100);
        check("cr_last_pos", 32'(pos), 0);
        check("cr_no_write", 32'(we_cycles - c0), 0);

        // Backspace at pos 5 and at pos 0
        do_clear();
        ack_mode = 1;
        for (int i = 0; i < 5; i++) begin
            send_key(1, 'h30 + i, 1);
            wait_drain(100);
        end
        check("bs_pre_pos", 32'(pos), 5);
        ack_mode = 0;
        send_key(1, 'h08, 1);
        check("bs_we", 32'(mem_we), 1);
        check("bs_addr", 32'(mem_addr), 32'h0f10);
        check("bs_data", mem_data, 32'h20);
        check("bs_pos_at_pop", 32'(pos), 4);
        ack_mode = 1;
        wait_drain(100);
        check("bs_pos", 32'(pos), 4);
        do_clear();
        c0 = we_cycles;
        send_key(1, 'h08, 1);
        wait_drain(100);
        check("bs0_pos", 32'(pos), 0);
        check("bs0_no_write", 32'(we_cycles - c0), 0);

        // Random key stream with random ack latency
        ack_mode = 2;
        for (int i = 0; i < 150; i++) begin
            int md = ($urandom_range(0, 9) < 7) ? 1 : $urandom_range(0, 7);
            send_key(md, rand_char(), $urandom_range(1, 3));
            if (fifo_count >= 10) wait_drain(3000);
        end
        wait_drain(6000);
        check("rand_pos", 32'(pos), 32'(m_pos));
        check("rand_pending", 32'(exp_addr.size()), 0);
        check("rand_no_ovf", 32'(overflow), 0);

        // Clear in the middle of a write with three entries queued
        ack_mode = 0;
        for (int i = 0; i < 4; i++) send_key(1, 'h70 + i, 1);
        check("mid_queued", 32'(fifo_count), 3);
        check("mid_issue", 32'(mem_we), 1);
        do_clear();
        check("mid_we", 32'(mem_we), 0);
        check("mid_count", 32'(fifo_count), 0);
        check("mid_pos", 32'(pos), 0);
        check("mid_ovf", 32'(overflow), 0);
        ack_mode = 1;
        c0 = we_cycles;
        repeat (6) @(negedge clk);
        check("mid_late_ack_we", 32'(we_cycles - c0), 0);
        check("mid_late_ack_kchg", 32'(k_change), 0);
        check("mid_late_ack_pos", 32'(pos), 0);
        check("mid_late_ack_cnt", 32'(fifo_count), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/kbd_text_writer.md
# kbd_text_writer

Parametrised keyboard-to-text-memory bridge: captures decoded key characters from the PS/2 keyboard decoder into a FIFO, then drains them one at a time into the memory-mapped text buffer through a write handshake. It replaces the fixed single-character mailbox with the following:
- a buffered input path, so no keystrokes are lost while memory is busy;
- cursor tracking with wrap-around;
- CR/LF and backspace handling;
- an overflow indication.

It sits between the keyboard decoder and the VGA/CPU text RAM arbiter.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- ADDR_W, 19: memory address width.
- BASE_ADDR, 19'hf00: byte address of text cell 0.
- LINE_LEN, 70: characters per line.
- LINES, 30: lines on screen; cursor range 0..LINE_LEN*LINES-1.
- PULSE_LEN, 32: cycles `k_change` is held high after each completed write.

Ports:
- CLOCK_50 in 1: sole clock; everything is on the rising edge.
- rst_n in 1: synchronous, active-low reset.
- clear in 1: synchronous soft clear, active-high.
- key_ready in 1: decoder "character available" level; only its rising edge counts.
- key_ascii in 8: character code, valid while `key_ready` is high.
- key_mode in 3: decoder mode.
- mem_we out 1: write request.
- mem_addr out ADDR_W: BASE_ADDR + 4*cursor, truncated to ADDR_W.
- mem_data out 32: {24'b0, char}.
- mem_ack in 1: write accepted; sampled only while `mem_we`=1.
- k_change out 1: display-refresh strobe.
- pos out CUR_W: current cursor, where CUR_W = clog2(LINE_LEN*LINES).
- fifo_count out clog2(DEPTH)+1: current occupancy.
- overflow out 1: sticky; set when a key is dropped because the FIFO is full.

## Operation
- **Capture:** rise = key_ready & ~key_ready_q. On a rise edge, key_ascii is pushed if both of these hold:
  - key_ascii ≠ 0;
  - key_mode ∈ {1,3,4}.
  All other rises are ignored.
- **Full FIFO:** a push is dropped and `overflow` is set, unless a pop happens on the same edge; in that case the push is accepted.
- **Drain FSM states:** IDLE, ISSUE, HOLD.
- **IDLE:** if the FIFO is non-empty, pop the head into `ch` and classify it:
  - **Printable (0x20–0x7E):**
    - Drive mem_addr = BASE_ADDR + 4*pos and mem_data = ch.
    - Set mem_we=1 and go to ISSUE.
  - **0x0D or 0x0A:**
    - pos ← start of the next line; the last line wraps to 0.
    - No write; stay in IDLE.
  - **0x08 with pos>0:**
    - pos ← pos−1.
    - Write 0x20 at the new pos: mem_we=1, go to ISSUE.
  - **0x08 with pos=0:** discard, no write.
  - **Any other code:** discard, stay in IDLE.
- **ISSUE:** hold mem_we, mem_addr and mem_data stable until `mem_ack`=1. On the ack edge:
  - mem_we ← 0.
  - For a printable char, pos ← pos+1; pos = LINE_LEN*LINES−1 wraps to 0.
  - k_change ← 1; go to HOLD.
- **HOLD:** count PULSE_LEN cycles with k_change=1, then k_change ← 0 and go to IDLE. Capture continues during ISSUE and HOLD.
- **clear=1** (priority over everything except rst_n):
  - FIFO flushed, pos ← 0, overflow ← 0;
  - FSM ← IDLE, mem_we ← 0, k_change ← 0.
  - A rise on the same edge is discarded.
- **rst_n=0:** same as clear. Additionally key_ready_q ← 0, mem_addr ← BASE_ADDR and mem_data ← 0. All outputs are 0 except mem_addr.
- Reset or clear mid-ISSUE abandons the write. The environment must treat a later mem_ack as a no-op; the block ignores acks when mem_we=0.

## Timing
- **Capture to write request:** rise sampled at edge t0 pushes at t0. The pop at edge t1 asserts mem_we after t1. Latency rise→mem_we is 2 cycles when the FIFO is empty and the FSM is in IDLE.
- **Write phase:** mem_we lasts ≥1 cycle, ending on the ack edge. k_change is high for exactly PULSE_LEN cycles starting at the ack edge.
- **Throughput:** one written char per (ack wait + 1 + PULSE_LEN + 1) cycles. Non-written codes cost one IDLE cycle.
- **Cursor update:**
  - Printable: pos updates on the ack edge.
  - Backspace: pos updates at the pop edge, so mem_addr already reflects the decremented cursor.
  - CR/LF: pos updates at the pop edge.
- **fifo_count:** updates on the push/pop edge; a simultaneous push and pop leaves it unchanged.

## Test plan
- **Single char:** reset, then key_mode=1, key_ascii=0x41, key_ready high for 3 cycles, mem_ack tied 1. Expect:
  - mem_we high for 1 cycle, 2 cycles after the rise, with mem_addr=0xf00 and mem_data=0x41;
  - k_change high for 32 cycles;
  - pos=1.
- **Mode/zero filter:** rises with (mode=2, 0x41), (mode=1, 0x00) and (mode=5, 0x42). Expect no push, fifo_count=0 and no mem_we.
- **Buffering/overflow:** hold mem_ack=0 and send 18 rises of mode=1 printable chars. Expect:
  - first char in ISSUE, fifo_count=16, overflow=1;
  - after releasing the ack, exactly 17 writes in order.
- **Wrap:**
  - Drive pos to 2099 and send 'Z'. Expect a write at 0xf00+4*2099 and pos=0.
  - At pos 2080 send 0x0D. Expect pos=0 and no write.
- **Backspace:**
  - At pos=5 send 0x08. Expect a write of 0x20 at 0xf00+16 and pos=4.
  - At pos=0 send 0x08. Expect no write and pos=0.
- **Mid-operation clear:** during ISSUE with 3 entries queued, pulse clear. Expect on the next edge:
  - mem_we=0, fifo_count=0, pos=0, overflow=0;
  - a subsequent mem_ack causes no state change.
